// File: rtl/queue_query_responder.sv
// queue_query_responder
//   Bounded circular queue (first-word fall-through) with a request/response
//   query port. A query reports array geometry of the queue contents
//   (LOW, HIGH, LEFT, RIGHT, SIZE, INCREMENT) or reads one element by index.
//   The query sees a snapshot of head and count taken in its accept cycle.
//
// Ports
//   clk, rst_n                  clock (rising edge), async active-low reset
//   flush                       synchronous clear of head/tail/count
//   push_valid/ready/data       append at tail
//   pop_valid/ready/data        remove from head, pop_data = mem[head]
//   qry_valid/ready/op/index    query request (op 0..7, index for READ)
//   rsp_valid/ready/data/err    registered query response, held until consumed
module queue_query_responder #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push_valid,
  output logic              push_ready,
  input  logic [DATA_W-1:0] push_data,
  output logic              pop_valid,
  input  logic              pop_ready,
  output logic [DATA_W-1:0] pop_data,
  input  logic              qry_valid,
  output logic              qry_ready,
  input  logic [2:0]        qry_op,
  input  logic [ADDR_W:0]   qry_index,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic              rsp_err
);

  // Bits of an element that fit in the 32-bit response.
  localparam int CW = (DATA_W < 32) ? DATA_W : 32;

  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  localparam logic [2:0] OP_LOW   = 3'd0;
  localparam logic [2:0] OP_HIGH  = 3'd1;
  localparam logic [2:0] OP_LEFT  = 3'd2;
  localparam logic [2:0] OP_RIGHT = 3'd3;
  localparam logic [2:0] OP_SIZE  = 3'd4;
  localparam logic [2:0] OP_INCR  = 3'd5;
  localparam logic [2:0] OP_READ  = 3'd6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    RESP    = 2'd2
  } state_t;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_head;
  logic [ADDR_W-1:0] r_tail;
  logic [ADDR_W:0]   r_count;

  state_t            r_state;
  logic [2:0]        r_op;
  logic [ADDR_W:0]   r_index;
  logic [ADDR_W-1:0] r_head_s;
  logic [ADDR_W:0]   r_count_s;
  logic              r_rsp_valid;
  logic [31:0]       r_rsp_data;
  logic              r_rsp_err;

  logic              w_push_fire;
  logic              w_pop_fire;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [DATA_W-1:0] w_rd_data;
  logic [31:0]       w_n32;
  logic [31:0]       w_result;
  logic              w_err;

  // Push is blocked while a query is capturing so the snapshot slots stay intact.
  assign push_ready  = (r_count != CNT_FULL) && (r_state != CAPTURE);
  assign pop_valid   = (r_count != '0);
  assign pop_data    = r_mem[r_head];
  assign qry_ready   = (r_state == IDLE);
  assign rsp_valid   = r_rsp_valid;
  assign rsp_data    = r_rsp_data;
  assign rsp_err     = r_rsp_err;

  assign w_push_fire = push_valid & push_ready;
  assign w_pop_fire  = pop_valid & pop_ready;

  // Element storage; never cleared, flush only moves the pointers.
  always_ff @(posedge clk) begin
    if (w_push_fire && !flush) begin
      r_mem[r_tail] <= push_data;
    end
  end

  // Head/tail/count bookkeeping; flush overrides any push/pop in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_fire) begin
        r_tail <= r_tail + PTR_ONE;
      end
      if (w_pop_fire) begin
        r_head <= r_head + PTR_ONE;
      end
      case ({w_push_fire, w_pop_fire})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Query result from the snapshot; the read address wraps modulo DEPTH.
  always_comb begin
    w_rd_addr = r_head_s + r_index[ADDR_W-1:0];
    w_rd_data = r_mem[w_rd_addr];
    w_n32     = 32'(r_count_s);
    w_result  = 32'd0;
    w_err     = 1'b0;
    case (r_op)
      OP_LOW:   w_result = 32'd0;
      OP_HIGH:  w_result = w_n32 - 32'd1;
      OP_LEFT:  w_result = 32'd0;
      OP_RIGHT: w_result = w_n32 - 32'd1;
      OP_SIZE:  w_result = w_n32;
      // LEFT (0) >= RIGHT (N-1) only when N <= 1.
      OP_INCR:  w_result = (r_count_s <= CNT_ONE) ? 32'd1 : 32'hFFFF_FFFF;
      OP_READ: begin
        if (r_index < r_count_s) begin
          w_result = 32'(w_rd_data[CW-1:0]);
        end else begin
          w_err = 1'b1;
        end
      end
      default:  w_err = 1'b1;
    endcase
  end

  // Query FSM: snapshot on accept, compute for one cycle, hold response until consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_op        <= 3'd0;
      r_index     <= '0;
      r_head_s    <= '0;
      r_count_s   <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 32'd0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (qry_valid) begin
            r_op      <= qry_op;
            r_index   <= qry_index;
            r_head_s  <= r_head;
            r_count_s <= r_count;
            r_state   <= CAPTURE;
          end
        end
        CAPTURE: begin
          r_rsp_data  <= w_result;
          r_rsp_err   <= w_err;
          r_rsp_valid <= 1'b1;
          r_state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_queue_query_responder.sv
module tb_queue_query_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic        push_valid = 1'b0;
  logic        push_ready;
  logic [31:0] push_data = 32'd0;
  logic        pop_valid;
  logic        pop_ready = 1'b0;
  logic [31:0] pop_data;
  logic        qry_valid = 1'b0;
  logic        qry_ready;
  logic [2:0]  qry_op = 3'd0;
  logic [4:0]  qry_index = 5'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_err;

  int n_cmp  = 0;
  int n_fail = 0;
  logic chk_en = 1'b0;

  queue_query_responder #(.DATA_W(32), .DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .push_valid(push_valid), .push_ready(push_ready), .push_data(push_data),
    .pop_valid(pop_valid), .pop_ready(pop_ready), .pop_data(pop_data),
    .qry_valid(qry_valid), .qry_ready(qry_ready), .qry_op(qry_op), .qry_index(qry_index),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  logic [31:0] mq[$];     // queue contents, front = head
  logic [31:0] snap[$];   // copy of the queue taken when a query is accepted
  int          phase = 0; // 0 idle, 1 capturing, 2 responding
  int          s_op, s_idx;
  logic        e_valid = 1'b0;
  logic [31:0] e_data = 32'd0;
  logic        e_err = 1'b0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      mq.delete(); snap.delete();
      phase = 0; e_valid = 1'b0; e_data = 32'd0; e_err = 1'b0;
    end else begin
      bit push_f, pop_f;
      int n;
      push_f = push_valid && (mq.size() != 16) && (phase != 1);
      pop_f  = pop_ready && (mq.size() != 0);
      case (phase)
        0: if (qry_valid) begin
             snap = mq; s_op = int'(qry_op); s_idx = int'(qry_index); phase = 1;
           end
        1: begin
             n = snap.size();
             e_err = 1'b0; e_data = 32'd0;
             case (s_op)
               1, 3:    e_data = 32'(n - 1);
               4:       e_data = 32'(n);
               5:       e_data = (0 >= n - 1) ? 32'd1 : 32'hFFFF_FFFF;
               6:       if (s_idx < n) e_data = snap[s_idx]; else e_err = 1'b1;
               7:       e_err = 1'b1;
               default: e_data = 32'd0;
             endcase
             e_valid = 1'b1; phase = 2;
           end
        default: if (rsp_ready) begin e_valid = 1'b0; phase = 0; end
      endcase
      if (flush) mq.delete();
      else begin
        if (pop_f) void'(mq.pop_front());
        if (push_f) mq.push_back(push_data);
      end
    end
  end

  // Compare DUT against the model on every falling edge.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("push_ready", push_ready, ((mq.size() != 16) && (phase != 1)) ? 32'd1 : 32'd0);
      chk("pop_valid", pop_valid, (mq.size() != 0) ? 32'd1 : 32'd0);
      if (mq.size() != 0) chk("pop_data", pop_data, mq[0]);
      chk("qry_ready", qry_ready, (phase == 0) ? 32'd1 : 32'd0);
      chk("rsp_valid", rsp_valid, e_valid);
      if (e_valid) begin
        chk("rsp_data", rsp_data, e_data);
        chk("rsp_err", rsp_err, e_err);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [31:0] d);
    int g = 0;
    push_valid = 1'b1; push_data = d;
    while (!push_ready && g < 20) begin step(); g++; end
    if (g == 20) chk("push_timeout", 32'd1, 32'd0);
    step();
    push_valid = 1'b0;
  endtask

  task automatic pop();
    pop_ready = 1'b1; step(); pop_ready = 1'b0;
  endtask

  // lat counts cycles with the accept cycle as cycle 0.
  task automatic do_query(input logic [2:0] op, input logic [4:0] idx, input bit pop_too,
                          input int hold, input bit flush_mid,
                          output logic [31:0] d, output logic e, output int lat);
    int g = 0;
    qry_valid = 1'b1; qry_op = op; qry_index = idx;
    while (!qry_ready && g < 20) begin step(); g++; end
    if (g == 20) chk("qry_accept_timeout", 32'd1, 32'd0);
    if (pop_too) pop_ready = 1'b1;
    step();
    qry_valid = 1'b0; pop_ready = 1'b0;
    if (flush_mid) flush = 1'b1;
    lat = 1;
    while (!rsp_valid && lat < 20) begin step(); flush = 1'b0; lat++; end
    flush = 1'b0;
    if (lat == 20) chk("rsp_timeout", 32'd1, 32'd0);
    d = rsp_data; e = rsp_err;
    for (int i = 0; i < hold; i++) begin
      chk("hold_data", rsp_data, d);
      chk("hold_qry_ready", qry_ready, 32'd0);
      step();
    end
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic e;
    int lat;
    logic [31:0] exp6 [6];
    exp6[0] = 32'd0; exp6[1] = 32'd2; exp6[2] = 32'd0;
    exp6[3] = 32'd2; exp6[4] = 32'd3; exp6[5] = 32'hFFFF_FFFF;

    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    step(); step();
    rst_n = 1'b1;
    step();
    chk("rst_rsp_valid", rsp_valid, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_err", rsp_err, 32'd0);
    chk("rst_pop_valid", pop_valid, 32'd0);
    chk("rst_push_ready", push_ready, 32'd1);
    chk("rst_qry_ready", qry_ready, 32'd1);

    // empty queue geometry
    do_query(3'd4, 5'd0, 1'b0, 0, 1'b0, d, e, lat);
    chk("empty_size", d, 32'd0); chk("empty_size_err", e, 32'd0); chk("latency", lat, 32'd2);
    do_query(3'd1, 5'd0, 1'b0, 0, 1'b0, d, e, lat);
    chk("empty_high", d, 32'hFFFF_FFFF);
    do_query(3'd5, 5'd0, 1'b0, 0, 1'b0, d, e, lat);
    chk("empty_incr", d, 32'd1); chk("empty_incr_err", e, 32'd0);

    // three elements
    push(32'd10); push(32'd20); push(32'd30);
    for (int op = 0; op < 6; op++) begin
      do_query(3'(op), 5'd0, 1'b0, 0, 1'b0, d, e, lat);
      chk("geom3", d, exp6[op]); chk("geom3_err", e, 32'd0);
    end
    do_query(3'd6, 5'd1, 1'b0, 0, 1'b0, d, e, lat);
    chk("read1", d, 32'd20); chk("read1_err", e, 32'd0);
    do_query(3'd6, 5'd3, 1'b0, 0, 1'b0, d, e, lat);
    chk("read3_data", d, 32'd0); chk("read3_err", e, 32'd1);

    // fill, full-queue push+pop, drain, wrap
    for (int i = 4; i <= 16; i++) push(32'(i * 10));
    chk("full_push_ready", push_ready, 32'd0);
    push_valid = 1'b1; push_data = 32'd999; pop_ready = 1'b1;
    chk("full_pop_head", pop_data, 32'd10);
    step();
    push_valid = 1'b0; pop_ready = 1'b0;
    chk("after_pop_push_ready", push_ready, 32'd1);
    do_query(3'd4, 5'd0, 1'b0, 0, 1'b0, d, e, lat);
    chk("size15", d, 32'd15);
    for (int i = 0; i < 15; i++) pop();
    chk("drained", pop_valid, 32'd0);
    for (int i = 0; i < 5; i++) push(32'(100 + i));
    do_query(3'd4, 5'd0, 1'b0, 0, 1'b0, d, e, lat);
    chk("size5", d, 32'd5);
    pop();

    // query in the same cycle as a pop sees pre-pop state
    do_query(3'd4, 5'd0, 1'b1, 0, 1'b0, d, e, lat);
    chk("size_pre_pop", d, 32'd4);
    do_query(3'd6, 5'd0, 1'b1, 0, 1'b0, d, e, lat);
    chk("read0_pre_pop", d, 32'd102);

    // backpressure and reserved op
    do_query(3'd7, 5'd0, 1'b0, 5, 1'b0, d, e, lat);
    chk("op7_data", d, 32'd0); chk("op7_err", e, 32'd1);

    // flush during capture keeps the snapshot
    do_query(3'd4, 5'd0, 1'b0, 0, 1'b1, d, e, lat);
    chk("flush_snap_size", d, 32'd2);
    do_query(3'd4, 5'd0, 1'b0, 0, 1'b0, d, e, lat);
    chk("flush_after_size", d, 32'd0);

    // reset while a response is pending
    push(32'd7); push(32'd8);
    qry_valid = 1'b1; qry_op = 3'd4;
    step(); qry_valid = 1'b0;
    step();
    chk("resp_before_reset", rsp_valid, 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("async_drop", rsp_valid, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_reset_pop_valid", pop_valid, 32'd0);
    do_query(3'd4, 5'd0, 1'b0, 0, 1'b0, d, e, lat);
    chk("post_reset_size", d, 32'd0);

    // randomized traffic, checked every cycle by the model
    for (int c = 0; c < 3000; c++) begin
      push_valid = ($urandom_range(0, 99) < 60);
      push_data  = $urandom();
      pop_ready  = ($urandom_range(0, 99) < 40);
      qry_valid  = ($urandom_range(0, 99) < 30);
      qry_op     = 3'($urandom_range(0, 7));
      qry_index  = 5'($urandom_range(0, 31));
      rsp_ready  = ($urandom_range(0, 99) < 50);
      flush      = ($urandom_range(0, 99) < 3);
      step();
    end
    push_valid = 1'b0; pop_ready = 1'b0; qry_valid = 1'b0; rsp_ready = 1'b0; flush = 1'b0;
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
